// File: rtl/serial_interp_fir.sv
// Serial polyphase interpolating FIR: one input sample yields L outputs, all
// taps evaluated through a single time-shared MAC with a double-buffered coefficient bank.
module serial_interp_fir #(
  parameter int L = 4,
  parameter int N = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [7:0]            x,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         coef_we,
  input  logic [$clog2(L*N)-1:0]       coef_addr,
  input  logic signed [7:0]            coef_data,
  output logic signed [15:0]           y,
  output logic                         out_valid,
  output logic [$clog2(L)-1:0]         out_phase
);

  localparam int T  = L * N;
  localparam int PW = $clog2(L);
  localparam int KW = $clog2(N);
  localparam int AW = $clog2(T);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]         state;
  logic signed [7:0]  d      [N];
  logic signed [7:0]  shadow [T];
  logic signed [7:0]  active [T];
  logic [PW-1:0]      p;
  logic [KW-1:0]      k;
  logic signed [17:0] acc;
  logic [AW-1:0]      tap;
  logic signed [15:0] prod;
  logic signed [15:0] sat;

  assign in_ready = (state == IDLE);

  // Phase p of the polyphase decomposition uses every L-th tap starting at p.
  assign tap  = AW'(k) * AW'(L) + AW'(p);
  assign prod = active[tap] * d[k];

  always_comb begin
    sat = acc[15:0];
    if (acc > 18'sd32767)
      sat = 16'sh7fff;
    else if (acc < -18'sd32768)
      sat = 16'sh8000;
  end

  // Shadow bank accepts writes at any time; the MAC only ever reads the active copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < T; i++)
        shadow[i] <= '0;
    end else if (coef_we) begin
      shadow[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      p         <= '0;
      k         <= '0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      out_phase <= '0;
      for (int i = 0; i < N; i++)
        d[i] <= '0;
      for (int i = 0; i < T; i++)
        active[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = N - 1; i > 0; i--)
              d[i] <= d[i-1];
            d[0] <= x;
            for (int i = 0; i < T; i++)
              active[i] <= shadow[i];
            p     <= '0;
            k     <= '0;
            acc   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + {{2{prod[15]}}, prod};
          if (k == KW'(N - 1))
            state <= OUT;
          else
            k <= k + 1'b1;
        end
        OUT: begin
          y         <= sat;
          out_valid <= 1'b1;
          out_phase <= p;
          if (p != PW'(L - 1)) begin
            p     <= p + 1'b1;
            k     <= '0;
            acc   <= '0;
            state <= MAC;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_interp_fir.sv
// Directed self-checking bench for serial_interp_fir: impulse, saturation,
// shadow coefficient bank, mid-sample reset and continuous-input throughput.
module tb_serial_interp_fir;

  logic               clk;
  logic               rst;
  logic signed [7:0]  x;
  logic               in_valid;
  logic               in_ready;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [7:0]  coef_data;
  logic signed [15:0] y;
  logic               out_valid;
  logic [1:0]         out_phase;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic signed [15:0] yq[$];
  logic [1:0]         phq[$];
  int                 oeq[$];
  int                 accq[$];

  serial_interp_fir dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y(y), .out_valid(out_valid), .out_phase(out_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every output pulse and every accept edge, sampled mid-low-phase.
  always @(negedge clk) begin
    #1;
    if (out_valid) begin
      yq.push_back(y);
      phq.push_back(out_phase);
      oeq.push_back(cyc);
    end
    if (in_valid && in_ready && rst)
      accq.push_back(cyc + 1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_queues();
    yq.delete();
    phq.delete();
    oeq.delete();
    accq.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_queues();
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 8'(val);
  endtask

  task automatic end_writes();
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send_sample(input int val);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    x        = 8'(val);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    x        = '0;
  endtask

  task automatic wait_outputs(input int n, input string tag);
    int t;
    t = 0;
    while (yq.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (yq.size() != n) begin
      errors++;
      $display("FAIL %s output count: got %0d, expected %0d", tag, yq.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, expected 0", out_valid); end
    if (y !== 16'sd0) begin errors++; $display("FAIL reset y: got %0d, expected 0", y); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b, expected 1", in_ready); end
    if (out_phase !== 2'd0) begin errors++; $display("FAIL reset out_phase: got %0d, expected 0", out_phase); end
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b, expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post-reset out_valid: got %b, expected 0", out_valid); end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 16; i++) write_coef(i, i + 1);
    end_writes();
    clear_queues();
    send_sample(1);
    wait_outputs(4, "impulse s0");
    for (int p = 0; p < 4; p++) begin
      if (p < oeq.size() && accq.size() > 0) begin
        checks++;
        if (oeq[p] - accq[0] != 5 * (p + 1)) begin
          errors++;
          $display("FAIL impulse latency p%0d: got %0d, expected %0d", p, oeq[p] - accq[0], 5 * (p + 1));
        end
      end
    end
    send_sample(0);
    wait_outputs(8, "impulse s1");
    send_sample(0);
    wait_outputs(12, "impulse s2");
    send_sample(0);
    wait_outputs(16, "impulse s3");
    for (int i = 0; i < 16; i++) begin
      if (i < yq.size()) begin
        checks += 2;
        if (yq[i] !== 16'(i + 1)) begin
          errors++;
          $display("FAIL impulse y[%0d]: got %0d, expected %0d", i, yq[i], i + 1);
        end
        if (phq[i] !== 2'(i % 4)) begin
          errors++;
          $display("FAIL impulse phase[%0d]: got %0d, expected %0d", i, phq[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int exp_pos[16] = '{16384, 16384, 16384, 16384, 32767, 32767, 32767, 32767,
                        32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    for (int i = 0; i < 16; i++) write_coef(i, -128);
    end_writes();
    clear_queues();
    for (int s = 0; s < 4; s++) begin
      send_sample(-128);
      wait_outputs(4 * (s + 1), "sat positive");
    end
    for (int i = 0; i < 16; i++) begin
      if (i < yq.size()) begin
        checks++;
        if (yq[i] !== 16'(exp_pos[i])) begin
          errors++;
          $display("FAIL sat positive y[%0d]: got %0d, expected %0d", i, yq[i], exp_pos[i]);
        end
      end
    end
    for (int i = 0; i < 16; i++) write_coef(i, 127);
    end_writes();
    clear_queues();
    send_sample(-128);
    wait_outputs(4, "sat negative");
    for (int i = 0; i < 4; i++) begin
      if (i < yq.size()) begin
        checks++;
        if (yq[i] !== -16'sd32768) begin
          errors++;
          $display("FAIL sat negative y[%0d]: got %0d, expected -32768", i, yq[i]);
        end
      end
    end
  endtask

  task automatic test_shadow_bank();
    int exp_sh[8] = '{10, 10, 10, 10, 20, 20, 20, 20};
    apply_reset();
    for (int i = 0; i < 16; i++) write_coef(i, 1);
    end_writes();
    clear_queues();
    send_sample(10);
    // First rewrite lands on edge E3, the rest follow while the sample is still being computed.
    @(negedge clk);
    for (int i = 0; i < 16; i++) write_coef(i, 2);
    end_writes();
    wait_outputs(4, "shadow s0");
    send_sample(0);
    wait_outputs(8, "shadow s1");
    for (int i = 0; i < 8; i++) begin
      if (i < yq.size()) begin
        checks++;
        if (yq[i] !== 16'(exp_sh[i])) begin
          errors++;
          $display("FAIL shadow y[%0d]: got %0d, expected %0d", i, yq[i], exp_sh[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    send_sample(5);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b, expected 0", out_valid); end
    if (y !== 16'sd0) begin errors++; $display("FAIL midreset y: got %0d, expected 0", y); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset in_ready: got %b, expected 1", in_ready); end
    clear_queues();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL release out_valid: got %b, expected 0", out_valid); end
    if (y !== 16'sd0) begin errors++; $display("FAIL release y: got %0d, expected 0", y); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release in_ready: got %b, expected 1", in_ready); end
    repeat (25) @(negedge clk);
    checks++;
    if (yq.size() != 0) begin
      errors++;
      $display("FAIL midreset stray outputs: got %0d, expected 0", yq.size());
    end
    send_sample(1);
    wait_outputs(4, "midreset s0");
    for (int s = 1; s < 4; s++) begin
      send_sample(0);
      wait_outputs(4 * (s + 1), "midreset impulse");
    end
    for (int i = 0; i < 16; i++) begin
      if (i < yq.size()) begin
        checks++;
        if (yq[i] !== 16'sd0) begin
          errors++;
          $display("FAIL midreset impulse y[%0d]: got %0d, expected 0", i, yq[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_c[12] = '{1, 2, 3, 4, 27, 50, 73, 96, 162, 228, 294, 360};
    apply_reset();
    for (int i = 0; i < 16; i++) write_coef(i, i + 1);
    end_writes();
    clear_queues();
    @(negedge clk);
    // x changes every cycle; only the values on edges 0, 21 and 42 may be taken.
    for (int t = 0; t < 43; t++) begin
      x        = 8'(t + 1);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    x        = '0;
    wait_outputs(12, "continuous");
    repeat (30) @(negedge clk);
    checks += 2;
    if (yq.size() != 12) begin
      errors++;
      $display("FAIL continuous pulse count: got %0d, expected 12", yq.size());
    end
    if (accq.size() != 3) begin
      errors++;
      $display("FAIL continuous accept count: got %0d, expected 3", accq.size());
    end
    if (accq.size() == 3) begin
      checks += 2;
      if (accq[1] - accq[0] != 21) begin errors++; $display("FAIL accept spacing 1: got %0d, expected 21", accq[1] - accq[0]); end
      if (accq[2] - accq[0] != 42) begin errors++; $display("FAIL accept spacing 2: got %0d, expected 42", accq[2] - accq[0]); end
    end
    for (int i = 0; i < 12; i++) begin
      if (i < yq.size()) begin
        checks += 2;
        if (yq[i] !== 16'(exp_c[i])) begin
          errors++;
          $display("FAIL continuous y[%0d]: got %0d, expected %0d", i, yq[i], exp_c[i]);
        end
        if (oeq[i] - oeq[0] != 5 * i + (i / 4)) begin
          errors++;
          $display("FAIL continuous pulse edge[%0d]: got %0d, expected %0d", i, oeq[i] - oeq[0], 5 * i + (i / 4));
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    x         = '0;
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    test_reset();
    test_impulse();
    test_saturation();
    test_shadow_bank();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
